diagv2_syscall_unit: RTL and testbench
======================================

DIAGV2_SYSCALL_UNIT -- requirements
Module: diagv2_syscall_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 64: core register and data-memory line width; power of 2, at least 16.
REQ-002 SHALL have parameter ADDR_W, default 12: data-memory line-index width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: character FIFO entries; power of 2, at least 2.
REQ-004 SHALL have parameter MAX_STR, default 1024: maximum characters per print.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port ecall_i, input, 1 bit: one-cycle ecall pulse from the core.
REQ-008 SHALL have ports syscall_i and arg0_i, inputs, DATA_W bits each: a7 (x17) and a0 (x10) values, valid while ecall_i is high.
REQ-009 SHALL have port halt_o, output, 1 bit: core stall.
REQ-010 SHALL have ports mem_req_o (output, 1 bit), mem_addr_o (output, ADDR_W bits) and mem_rdata_i (input, DATA_W bits): a read-only data-memory port; rdata is valid exactly one cycle after req.
REQ-011 SHALL have ports char_valid_o (output, 1), char_data_o (output, 8) and char_ready_i (input, 1): the console byte stream.
REQ-012 SHALL have ports exit_valid_o (output, 1) and exit_code_o (output, DATA_W): the sticky program exit.
REQ-013 SHALL have port err_o, output, 1 bit: sticky error flag.
REQ-014 SHALL have port exit_cycles_o, output, 64 bits: cycle count at exit (see REQ-027).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, WAIT, SCAN, DONE.
REQ-016 SHALL sample ecall_i only in IDLE; halt_o SHALL rise on the next cycle and stay high until the syscall completes.
REQ-017 syscall 93 (EXIT) SHALL latch exit_code_o from arg0_i, set exit_valid_o, and enter DONE; DONE keeps halt_o high until reset.
REQ-018 syscall 11 (PUTCHAR) SHALL push arg0_i[7:0]; it SHALL hold halt_o while the FIFO is full, then return to IDLE and drop halt_o.
REQ-019 syscall 4 (PRINT) SHALL derive the start position from arg0_i:
- line = arg0_i >> log2(DATA_W/8);
- byte offset = arg0_i low bits;
- byte k of a line is bits [8k+7:8k] (little-endian).
REQ-020 PRINT flow:
- FETCH drives mem_req_o for one cycle; WAIT latches mem_rdata_i.
- SCAN examines one byte per cycle.
- A zero byte ends the print: return to IDLE and drop halt_o.
- A non-zero byte is pushed when the FIFO is not full, otherwise SCAN stalls.
- After the last byte of a line: offset returns to 0, line increments modulo 2^ADDR_W, and the FSM goes to FETCH.
REQ-021 PRINT reaching MAX_STR pushed characters without a terminator SHALL set err_o and return to IDLE, releasing halt_o.
REQ-022 Any other syscall number SHALL set err_o and enter DONE, with halt_o held.
REQ-023 The FIFO SHALL present char_valid_o = not-empty; a byte transfers when char_valid_o and char_ready_i are both high.
REQ-024 A simultaneous FIFO push and pop when full SHALL be allowed and keep the count unchanged.
REQ-025 The FIFO SHALL keep draining in every state, including DONE.

Reset
REQ-026 reset low SHALL asynchronously clear all state, mid-operation included:
- FSM returns to IDLE;
- FIFO is emptied;
- halt_o, mem_req_o, char_valid_o, exit_valid_o, err_o are 0;
- exit_code_o and exit_cycles_o are 0;
- char_data_o and mem_addr_o are 0.

Configuration
REQ-027 With DIAGV2_SYSCALL_CYCLES_EN defined:
- a 64-bit free-running counter clears on reset and counts every cycle;
- it is copied to exit_cycles_o when EXIT is accepted.
Without the macro, exit_cycles_o SHALL be constant 0 and no counter is built.

Structure
REQ-028 Syscall numbers (EXIT 93, PRINT 4, PUTCHAR 11) and the FSM state encoding SHALL be defined in diagv2_const.vh.
REQ-029 The FIFO SHALL be a sub-module diagv2_char_fifo, parametrised by depth and 8 bits wide.

Verification
REQ-030 EXIT: ecall_i with a7=93, a0=7 -> halt_o high from the next cycle forever, exit_valid_o=1, exit_code_o=7, char_valid_o stays 0.
REQ-031 PRINT crossing a line: memory holds "Hello, world\n\0" at address 0x13, char_ready_i=1 -> 13 bytes out in order, reads of lines 2 then 3, halt_o drops after the 0 byte.
REQ-032 PRINT backpressure: 40-char string, FIFO_DEPTH=16, char_ready_i=0 for 100 cycles -> exactly 16 bytes buffered and SCAN stalled; after release, all 40 bytes delivered with no loss or duplication.
REQ-033 Unterminated string: MAX_STR=8, memory all 'A' -> 8 bytes out, err_o=1, halt_o drops.
REQ-034 Invalid syscall: a7=5 -> err_o=1, halt_o held; then reset low mid-PRINT -> all outputs 0 and the FIFO empty immediately.
REQ-035 Cycle counter: with the macro defined, EXIT issued 100 cycles after reset release -> exit_cycles_o=100; without the macro -> 0.

Source files
------------

// File: rtl/diagv2_syscall_unit_pkg.sv
// Package wrapper so the syscall constants and state type are imported, not re-included.
package diagv2_syscall_unit_pkg;
`include "diagv2_const.vh"
endpackage

// File: rtl/diagv2_char_fifo.sv
// Byte-wide console FIFO; push and pop in the same cycle are legal even when full.
module diagv2_char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] data,
    output logic       valid,
    output logic       full
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_pop;

    assign valid  = (wr_ptr != rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop = pop && valid;
    assign data   = valid ? mem[rd_ptr[AW-1:0]] : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; an empty FIFO masks its output to zero instead.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/diagv2_const.vh
// Syscall numbers and FSM state encoding shared by the diagv2 syscall unit.
`ifndef DIAGV2_CONST_VH
`define DIAGV2_CONST_VH

localparam int SYS_PRINT   = 4;
localparam int SYS_PUTCHAR = 11;
localparam int SYS_EXIT    = 93;

typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_SCAN  = 3'd3,
    ST_DONE  = 3'd4
} state_t;

`endif

// File: rtl/diagv2_syscall_unit.sv
// Console/exit syscall unit for the diagv2 core (PRINT, PUTCHAR, EXIT).
// Define DIAGV2_SYSCALL_CYCLES_EN to build the cycle counter behind exit_cycles_o.
module diagv2_syscall_unit
    import diagv2_syscall_unit_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_STR    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ecall_i,
    input  logic [DATA_W-1:0] syscall_i,
    input  logic [DATA_W-1:0] arg0_i,
    output logic              halt_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              char_valid_o,
    output logic [7:0]        char_data_o,
    input  logic              char_ready_i,
    output logic              exit_valid_o,
    output logic [DATA_W-1:0] exit_code_o,
    output logic              err_o,
    output logic [63:0]       exit_cycles_o
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] line_q, line_nx;
    logic [OFF_W-1:0]  off_q, off_nx;
    logic [DATA_W-1:0] line_buf_q, line_buf_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic              single_q, single_nx;   // SCAN pushes one PUTCHAR byte, then stops
    logic              exit_set, err_set, push, fifo_full, fifo_room;
    logic [7:0]        cur_byte;
    logic              exit_valid_q, err_q;
    logic [DATA_W-1:0] exit_code_q;

    assign halt_o       = (state != ST_IDLE);
    assign mem_req_o    = (state == ST_FETCH);
    assign mem_addr_o   = line_q;
    assign exit_valid_o = exit_valid_q;
    assign exit_code_o  = exit_code_q;
    assign err_o        = err_q;
    assign fifo_room    = !fifo_full || char_ready_i;

    always_comb begin
        cur_byte = 8'h00;
        for (int k = 0; k < BYTES; k++)
            if (off_q == OFF_W'(k)) cur_byte = line_buf_q[8*k +: 8];
    end

    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    always_comb begin
        state_nx    = state;
        line_nx     = line_q;
        off_nx      = off_q;
        line_buf_nx = line_buf_q;
        cnt_nx      = cnt_q;
        single_nx   = single_q;
        exit_set    = 1'b0;
        err_set     = 1'b0;
        push        = 1'b0;
        unique case (state)
            ST_IDLE: if (ecall_i) begin
                if (syscall_i == DATA_W'(SYS_EXIT)) begin
                    exit_set = 1'b1;
                    state_nx = ST_DONE;
                end else if (syscall_i == DATA_W'(SYS_PUTCHAR)) begin
                    line_buf_nx = {{(DATA_W-8){1'b0}}, arg0_i[7:0]};
                    off_nx      = '0;
                    single_nx   = 1'b1;
                    state_nx    = ST_SCAN;
                end else if (syscall_i == DATA_W'(SYS_PRINT)) begin
                    line_nx   = arg0_i[OFF_W +: ADDR_W];
                    off_nx    = arg0_i[OFF_W-1:0];
                    cnt_nx    = '0;
                    single_nx = 1'b0;
                    state_nx  = ST_FETCH;
                end else begin
                    err_set  = 1'b1;
                    state_nx = ST_DONE;
                end
            end
            ST_FETCH: state_nx = ST_WAIT;
            ST_WAIT: begin
                line_buf_nx = mem_rdata_i;
                state_nx    = ST_SCAN;
            end
            ST_SCAN: begin
                if (single_q) begin
                    if (fifo_room) begin
                        push     = 1'b1;
                        state_nx = ST_IDLE;
                    end
                end else if (cur_byte == 8'h00) begin
                    state_nx = ST_IDLE;
                end else if (fifo_room) begin
                    push   = 1'b1;
                    cnt_nx = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(MAX_STR - 1)) begin
                        err_set  = 1'b1;
                        state_nx = ST_IDLE;
                    end else if (off_q == '1) begin
                        off_nx   = '0;
                        line_nx  = line_q + 1'b1;
                        state_nx = ST_FETCH;
                    end else begin
                        off_nx = off_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_nx = ST_DONE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            line_q       <= '0;
            off_q        <= '0;
            line_buf_q   <= '0;
            cnt_q        <= '0;
            single_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_code_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            state      <= state_nx;
            line_q     <= line_nx;
            off_q      <= off_nx;
            line_buf_q <= line_buf_nx;
            cnt_q      <= cnt_nx;
            single_q   <= single_nx;
            if (exit_set) begin
                exit_valid_q <= 1'b1;
                exit_code_q  <= arg0_i;
            end
            if (err_set) err_q <= 1'b1;
        end
    end

    diagv2_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (cur_byte),
        .pop       (char_ready_i),
        .data      (char_data_o),
        .valid     (char_valid_o),
        .full      (fifo_full)
    );

`ifdef DIAGV2_SYSCALL_CYCLES_EN
    logic [63:0] cycle_cnt, exit_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt     <= '0;
            exit_cycles_q <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 64'd1;
            if (exit_set) exit_cycles_q <= cycle_cnt;
        end
    end

    assign exit_cycles_o = exit_cycles_q;
`else
    assign exit_cycles_o = '0;
`endif
endmodule

// File: tb/tb_diagv2_syscall_unit.sv
// Randomized self-checking bench: a byte-addressed memory model and string walker predict
// the console stream, line fetches and error flag of diagv2_syscall_unit.
module tb_diagv2_syscall_unit;
    localparam int DATA_W     = 64;
    localparam int ADDR_W     = 6;
    localparam int FIFO_DEPTH = 16;
    localparam int MAX_STR    = 48;
    localparam int LINE_BYTES = DATA_W / 8;
    localparam int MEM_BYTES  = (1 << ADDR_W) * LINE_BYTES;

    logic              clk = 1'b0;
    logic              reset;
    logic              ecall_i;
    logic [DATA_W-1:0] syscall_i, arg0_i;
    logic              halt_o, mem_req_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_rdata_i;
    logic              char_valid_o, char_ready_i;
    logic [7:0]        char_data_o;
    logic              exit_valid_o, err_o;
    logic [DATA_W-1:0] exit_code_o;
    logic [63:0]       exit_cycles_o;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_rx     = 0;
    int         ready_mode = 0;        // 0 random, 1 always ready, 2 never ready
    logic [7:0] mem_b [MEM_BYTES];
    logic [7:0] exp_q[$];
    int         exp_lines[$];
    bit         pend = 1'b0;
    int         pend_line = 0;
    bit         err_exp = 1'b0;

    diagv2_syscall_unit #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_STR(MAX_STR)
    ) dut (
        .clk(clk), .reset(reset), .ecall_i(ecall_i), .syscall_i(syscall_i), .arg0_i(arg0_i),
        .halt_o(halt_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
        .char_valid_o(char_valid_o), .char_data_o(char_data_o), .char_ready_i(char_ready_i),
        .exit_valid_o(exit_valid_o), .exit_code_o(exit_code_o), .err_o(err_o),
        .exit_cycles_o(exit_cycles_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] got);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0h, expected nothing", name, got);
    endtask

    function automatic logic [DATA_W-1:0] line_word(input int ln);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < LINE_BYTES; k++) w[8*k +: 8] = mem_b[ln*LINE_BYTES + k];
        return w;
    endfunction

    // Walks the C string from a byte address exactly as a reader of memory would.
    task automatic model_print(input int addr, output bit hit_max);
        int p = addr % MEM_BYTES;
        int n = 0;
        bit first = 1'b1;
        hit_max = 1'b0;
        while (1) begin
            if (first || (p % LINE_BYTES) == 0) exp_lines.push_back(p / LINE_BYTES);
            first = 1'b0;
            if (mem_b[p] == 8'h00) break;
            exp_q.push_back(mem_b[p]);
            n++;
            if (n == MAX_STR) begin
                hit_max = 1'b1;
                break;
            end
            p = (p + 1) % MEM_BYTES;
        end
    endtask

    task automatic put_str(input int addr, input string s, input bit term);
        for (int i = 0; i < s.len(); i++) mem_b[(addr + i) % MEM_BYTES] = s[i];
        if (term) mem_b[(addr + s.len()) % MEM_BYTES] = 8'h00;
    endtask

    // Memory responder, ready driver and per-cycle compare of the output stream.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            case (ready_mode)
                1:       char_ready_i = 1'b1;
                2:       char_ready_i = 1'b0;
                default: char_ready_i = 1'($urandom_range(0, 1));
            endcase
            mem_rdata_i = pend ? line_word(pend_line) : {$urandom, $urandom};
            pend        = mem_req_o;
            pend_line   = int'(mem_addr_o);
            if (mem_req_o) begin
                if (exp_lines.size() == 0) unexpected("fetch_line", mem_addr_o);
                else chk("fetch_line", mem_addr_o, exp_lines.pop_front());
            end
            if (char_valid_o && char_ready_i) begin
                n_rx++;
                if (exp_q.size() == 0) unexpected("char_out", char_data_o);
                else chk("char_out", char_data_o, exp_q.pop_front());
            end
        end else begin
            pend = 1'b0;
        end
    end

    task automatic ecall(input int sc, input logic [63:0] a0);
        chk("idle_before_ecall", halt_o, 0);
        ecall_i   = 1'b1;
        syscall_i = 64'(sc);
        arg0_i    = a0;
        @(negedge clk);
        ecall_i   = 1'b0;
        syscall_i = {$urandom, $urandom};
        arg0_i    = {$urandom, $urandom};
        chk("halt_rises", halt_o, 1);
    endtask

    task automatic wait_idle(input int budget);
        int i = 0;
        while (halt_o && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("halt_released", halt_o, 0);
    endtask

    task automatic wait_drain(input int budget);
        int i = 0;
        while ((exp_q.size() != 0 || char_valid_o) && i < budget) begin
            @(negedge clk);
            i++;
        end
        chk("chars_left", exp_q.size(), 0);
        chk("lines_left", exp_lines.size(), 0);
        chk("fifo_empty", char_valid_o, 0);
    endtask

    task automatic do_print(input int addr, input int hi);
        bit m;
        model_print(addr, m);
        err_exp |= m;
        ecall(4, 64'(addr) | (64'(hi) << 9));
        wait_idle(2000);
        chk("err_after_print", err_o, err_exp);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_halt"}, halt_o, 0);
        chk({tag, "_mem_req"}, mem_req_o, 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
        chk({tag, "_char_valid"}, char_valid_o, 0);
        chk({tag, "_char_data"}, char_data_o, 0);
        chk({tag, "_exit_valid"}, exit_valid_o, 0);
        chk({tag, "_exit_code"}, exit_code_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_exit_cycles"}, exit_cycles_o, 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        exp_q.delete();
        exp_lines.delete();
        err_exp = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bit         m;
        logic [7:0] b;
        int         base;
        string      long_s;
        string      rs;
        logic [63:0] exp_cycles;

        reset = 1'b0; ecall_i = 1'b0; syscall_i = '0; arg0_i = '0;
        char_ready_i = 1'b0; mem_rdata_i = '0;
        for (int i = 0; i < MEM_BYTES; i++) mem_b[i] = 8'($urandom);
        repeat (2) @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("after_release");

        // "Hello, world\n" at 0x13: lines 2, 3 and 4 (terminator sits at 0x20).
        ready_mode = 1;
        put_str(32'h13, "Hello, world\n", 1'b1);
        model_print(32'h13, m);
        chk("hello_model_chars", exp_q.size(), 13);
        chk("hello_model_lines", exp_lines.size(), 3);
        chk("hello_model_line0", exp_lines[0], 2);
        chk("hello_model_line1", exp_lines[1], 3);
        chk("hello_model_max", m, 0);
        base = n_rx;
        ecall(4, 64'h13);
        wait_idle(200);
        wait_drain(200);
        chk("hello_rx_count", n_rx - base, 13);
        chk("hello_err", err_o, 0);

        // PUTCHAR under random backpressure.
        ready_mode = 0;
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            ecall(11, {$urandom, 24'($urandom), b});
            wait_idle(200);
        end
        wait_drain(500);

        // 40-character print held off for 100 cycles: 16 buffered, stalled fetching line 34.
        long_s = "";
        for (int i = 0; i < 40; i++) long_s = {long_s, string'(8'(8'h61 + i % 26))};
        put_str(32'h100, long_s, 1'b1);
        ready_mode = 2;
        base = n_rx;
        model_print(32'h100, m);
        chk("bp_model_lines", exp_lines.size(), 6);
        ecall(4, 64'h100);
        repeat (100) @(negedge clk);
        chk("bp_halt_held", halt_o, 1);
        chk("bp_valid", char_valid_o, 1);
        chk("bp_nothing_out", n_rx - base, 0);
        chk("bp_lines_left", exp_lines.size(), 3);
        ready_mode = 1;
        wait_idle(500);
        wait_drain(500);
        chk("bp_rx_count", n_rx - base, 40);

        // Random mix of PRINT and PUTCHAR with random ready.
        ready_mode = 0;
        for (int t = 0; t < 30; t++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                ecall(11, {32'($urandom), 24'($urandom), b});
                wait_idle(200);
            end else begin
                int a = $urandom_range(0, MEM_BYTES - 1);
                int len = $urandom_range(0, 20);
                rs = "";
                for (int i = 0; i < len; i++) rs = {rs, string'(8'($urandom_range(1, 255)))};
                put_str(a, rs, 1'b1);
                do_print(a, $urandom_range(0, 255));
            end
        end
        wait_drain(2000);

        // Print starting in the last line wraps to line 0.
        put_str(MEM_BYTES - 5, "wrap-test!", 1'b1);
        do_print(MEM_BYTES - 5, 0);
        wait_drain(500);

        // Unterminated string: MAX_STR characters, then err.
        ready_mode = 1;
        rs = "";
        for (int i = 0; i < 60; i++) rs = {rs, "A"};
        put_str(32'h40, rs, 1'b0);
        base = n_rx;
        do_print(32'h40, 0);
        wait_drain(500);
        chk("max_rx_count", n_rx - base, MAX_STR);
        chk("max_err", err_o, 1);
        exp_q.push_back(8'h2a);
        ecall(11, 64'h2a);
        wait_idle(50);
        wait_drain(50);
        chk("err_sticky", err_o, 1);

        // Invalid syscall enters DONE; the FIFO still drains there.
        do_reset();
        ready_mode = 2;
        exp_q.push_back(8'h51);
        ecall(11, 64'h51);
        wait_idle(50);
        ecall(5, 64'h0);
        repeat (10) @(negedge clk);
        chk("inv_halt_held", halt_o, 1);
        chk("inv_err", err_o, 1);
        chk("inv_exit_valid", exit_valid_o, 0);
        ready_mode = 1;
        wait_drain(50);
        chk("inv_halt_still", halt_o, 1);

        // Reset asserted in the middle of a stalled PRINT.
        do_reset();
        ready_mode = 2;
        model_print(32'h100, m);
        ecall(4, 64'h100);
        repeat (30) @(negedge clk);
        chk("mid_halt", halt_o, 1);
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_all_zero("reset_mid_print");
        exp_q.delete();
        exp_lines.delete();
        repeat (2) @(negedge clk);
        ready_mode = 1;
        reset = 1'b1;

        // EXIT 100 cycles after reset release.
        repeat (100) @(negedge clk);
        chk("post_reset_empty", char_valid_o, 0);
        ecall(93, 64'd7);
`ifdef DIAGV2_SYSCALL_CYCLES_EN
        exp_cycles = 64'd100;
`else
        exp_cycles = 64'd0;
`endif
        for (int i = 0; i < 20; i++) begin
            chk("exit_halt", halt_o, 1);
            chk("exit_no_char", char_valid_o, 0);
            @(negedge clk);
        end
        chk("exit_valid", exit_valid_o, 1);
        chk("exit_code", exit_code_o, 7);
        chk("exit_cycles", exit_cycles_o, exp_cycles);
        chk("exit_err", err_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1, "watchdog expired");
    end
endmodule
